// File: rtl/stopwatch_lap_ctrl_if.sv
// Control pulses, live time and display-side outputs for the lap controller.
// Master drives pulses and live time; slave (the controller) drives display and status.
interface stopwatch_lap_ctrl_if #(
  parameter int AW = 3
);
  logic          tick;
  logic          lap_pulse;
  logic          recall_pulse;
  logic          clear_pulse;
  logic          running;
  logic [7:0]    hours_in;
  logic [7:0]    minutes_in;
  logic [7:0]    seconds_in;
  logic [7:0]    centisec_in;
  logic [7:0]    hours_out;
  logic [7:0]    minutes_out;
  logic [7:0]    seconds_out;
  logic [7:0]    centisec_out;
  logic          recall_active;
  logic [AW-1:0] lap_index;
  logic [AW:0]   lap_count;
  logic          full;
  logic          overflow;

  modport master (
    output tick, lap_pulse, recall_pulse, clear_pulse, running,
    output hours_in, minutes_in, seconds_in, centisec_in,
    input  hours_out, minutes_out, seconds_out, centisec_out,
    input  recall_active, lap_index, lap_count, full, overflow
  );

  modport slave (
    input  tick, lap_pulse, recall_pulse, clear_pulse, running,
    input  hours_in, minutes_in, seconds_in, centisec_in,
    output hours_out, minutes_out, seconds_out, centisec_out,
    output recall_active, lap_index, lap_count, full, overflow
  );
endinterface

// File: rtl/stopwatch_lap_ctrl.sv
// Lap capture buffer and live/recall display arbiter; display output is registered (1 clk live, 2 clk on recall entry).
// Pulse-driven, no backpressure: captures while full are dropped and flagged in sticky overflow.
module stopwatch_lap_ctrl #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 500
) (
  input  logic                clk,
  input  logic                rst,
  stopwatch_lap_ctrl_if.slave bus
);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic {LIVE, RECALL} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_time;
  logic [AW-1:0] r_lap_index;
  logic [CW-1:0] r_lap_count;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_overflow;
  logic          w_full;
  logic          w_capture;
  logic          w_wr_en;
  logic          w_rec_req;
  logic          w_last;
  logic          w_recall_active;
  logic [31:0]   w_live;

  assign w_live    = {bus.hours_in, bus.minutes_in, bus.seconds_in, bus.centisec_in};
  assign w_full    = (r_lap_count == CW'(DEPTH));
  assign w_capture = bus.lap_pulse & bus.running & ~bus.clear_pulse;
  assign w_wr_en   = w_capture & ~w_full;
  assign w_rec_req = bus.recall_pulse & ~bus.clear_pulse;
  // Recall decisions use the pre-capture count even when a lap lands in the same cycle.
  assign w_last    = (CW'(r_lap_index) + CW'(1)) >= r_lap_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LIVE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear_pulse) begin
      w_state_nxt = LIVE;
    end else begin
      case (r_state)
        LIVE:    if (w_rec_req && r_lap_count != '0) w_state_nxt = RECALL;
        RECALL: begin
          if (w_rec_req) begin
            if (w_last) w_state_nxt = LIVE;
          end else if (bus.tick && r_tmo_cnt == TMO_MAX) begin
            w_state_nxt = LIVE;
          end
        end
        default: w_state_nxt = LIVE;
      endcase
    end
  end

  always_comb begin
    w_recall_active = (r_state == RECALL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_index <= '0;
      r_tmo_cnt   <= '0;
    end else if (w_state_nxt == LIVE) begin
      r_lap_index <= '0;
      r_tmo_cnt   <= '0;
    end else if (w_rec_req) begin
      r_lap_index <= (r_state == LIVE) ? '0 : r_lap_index + AW'(1);
      r_tmo_cnt   <= '0;
    end else if (bus.tick) begin
      r_tmo_cnt   <= r_tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lap_count <= '0;
      r_overflow  <= 1'b0;
    end else if (bus.clear_pulse) begin
      r_lap_count <= '0;
      r_overflow  <= 1'b0;
    end else if (w_wr_en) begin
      r_lap_count <= r_lap_count + CW'(1);
    end else if (w_capture) begin
      r_overflow  <= 1'b1;
    end
  end

  // Storage has no reset; the write pointer is the low bits of the lap count.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_lap_count[AW-1:0]] <= w_live;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_time <= '0;
    else if (r_state == RECALL) r_time <= r_mem[r_lap_index];
    else                       r_time <= w_live;
  end

  assign bus.hours_out     = r_time[31:24];
  assign bus.minutes_out   = r_time[23:16];
  assign bus.seconds_out   = r_time[15:8];
  assign bus.centisec_out  = r_time[7:0];
  assign bus.recall_active = w_recall_active;
  assign bus.lap_index     = r_lap_index;
  assign bus.lap_count     = r_lap_count;
  assign bus.full          = w_full;
  assign bus.overflow      = r_overflow;
endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: capture, recall walk, overflow, timeout, priority, async reset.
module tb_stopwatch_lap_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  stopwatch_lap_ctrl_if #(.AW(3)) bus();

  stopwatch_lap_ctrl #(.DEPTH(8), .AW(3), .TIMEOUT(500)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wire [31:0] disp = {bus.hours_out, bus.minutes_out, bus.seconds_out, bus.centisec_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_live(input logic [31:0] t);
    {bus.hours_in, bus.minutes_in, bus.seconds_in, bus.centisec_in} = t;
  endtask

  task automatic lap_step();
    bus.lap_pulse = 1'b1;
    step();
    bus.lap_pulse = 1'b0;
  endtask

  task automatic recall_step();
    bus.recall_pulse = 1'b1;
    step();
    bus.recall_pulse = 1'b0;
  endtask

  task automatic clear_step();
    bus.clear_pulse = 1'b1;
    step();
    bus.clear_pulse = 1'b0;
  endtask

  initial begin
    bus.tick = 1'b0; bus.lap_pulse = 1'b0; bus.recall_pulse = 1'b0;
    bus.clear_pulse = 1'b0; bus.running = 1'b0;
    set_live(32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_time", disp, 32'h0);
    chk("rst_recall", 32'(bus.recall_active), 32'h0);
    chk("rst_count", 32'(bus.lap_count), 32'h0);
    chk("rst_index", 32'(bus.lap_index), 32'h0);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_ovf", 32'(bus.overflow), 32'h0);
    rst = 1'b0;

    // 1: live pass-through
    bus.running = 1'b1;
    set_live(32'h01020345);
    step();
    chk("live_time", disp, 32'h01020345);
    chk("live_recall", 32'(bus.recall_active), 32'h0);
    chk("live_count", 32'(bus.lap_count), 32'h0);

    // 2: two laps, walk through them, exit
    set_live(32'h00000510); lap_step();
    chk("lap1_count", 32'(bus.lap_count), 32'h1);
    set_live(32'h00000977); lap_step();
    chk("lap2_count", 32'(bus.lap_count), 32'h2);
    set_live(32'h00001234);
    recall_step();
    chk("rec1_active", 32'(bus.recall_active), 32'h1);
    chk("rec1_index", 32'(bus.lap_index), 32'h0);
    chk("rec1_time_1clk", disp, 32'h00001234);
    step();
    chk("rec1_time_2clk", disp, 32'h00000510);
    recall_step();
    chk("rec2_index", 32'(bus.lap_index), 32'h1);
    step();
    chk("rec2_time", disp, 32'h00000977);
    set_live(32'h00002000);
    recall_step();
    chk("rec3_active", 32'(bus.recall_active), 32'h0);
    chk("rec3_index", 32'(bus.lap_index), 32'h0);
    step();
    chk("rec3_live", disp, 32'h00002000);

    // 3: fill, overflow, read back last slot, clear
    clear_step();
    chk("clr0_count", 32'(bus.lap_count), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      set_live(32'(i));
      lap_step();
    end
    chk("fill_count", 32'(bus.lap_count), 32'h8);
    chk("fill_full", 32'(bus.full), 32'h1);
    chk("fill_ovf", 32'(bus.overflow), 32'h1);
    recall_step();
    for (int i = 0; i < 7; i++) recall_step();
    chk("fill_index7", 32'(bus.lap_index), 32'h7);
    step();
    chk("fill_mem7", disp, 32'h00000008);
    clear_step();
    chk("clr_count", 32'(bus.lap_count), 32'h0);
    chk("clr_full", 32'(bus.full), 32'h0);
    chk("clr_ovf", 32'(bus.overflow), 32'h0);
    chk("clr_recall", 32'(bus.recall_active), 32'h0);

    // 4: recall timeout
    set_live(32'h00003300); lap_step();
    recall_step();
    chk("tmo_enter", 32'(bus.recall_active), 32'h1);
    bus.tick = 1'b1;
    repeat (499) step();
    chk("tmo_499", 32'(bus.recall_active), 32'h1);
    step();
    bus.tick = 1'b0;
    chk("tmo_500", 32'(bus.recall_active), 32'h0);
    chk("tmo_index", 32'(bus.lap_index), 32'h0);

    // 5: simultaneous events
    bus.clear_pulse = 1'b1; bus.lap_pulse = 1'b1; bus.recall_pulse = 1'b1;
    step();
    bus.clear_pulse = 1'b0; bus.lap_pulse = 1'b0; bus.recall_pulse = 1'b0;
    chk("clr_all_count", 32'(bus.lap_count), 32'h0);
    chk("clr_all_recall", 32'(bus.recall_active), 32'h0);
    set_live(32'h00004400);
    bus.lap_pulse = 1'b1; bus.recall_pulse = 1'b1;
    step();
    bus.lap_pulse = 1'b0; bus.recall_pulse = 1'b0;
    chk("laprec_count", 32'(bus.lap_count), 32'h1);
    chk("laprec_recall", 32'(bus.recall_active), 32'h0);
    bus.running = 1'b0;
    lap_step();
    chk("stopped_lap", 32'(bus.lap_count), 32'h1);
    bus.running = 1'b1;

    // 6: async reset mid-recall
    set_live(32'h00004401); lap_step();
    set_live(32'h00004402); lap_step();
    chk("pre_rst_count", 32'(bus.lap_count), 32'h3);
    recall_step();
    step();
    chk("pre_rst_time", disp, 32'h00004400);
    chk("pre_rst_recall", 32'(bus.recall_active), 32'h1);
    #3 rst = 1'b1;
    #1;
    chk("arst_time", disp, 32'h0);
    chk("arst_recall", 32'(bus.recall_active), 32'h0);
    chk("arst_count", 32'(bus.lap_count), 32'h0);
    #1 rst = 1'b0;
    recall_step();
    chk("post_rst_recall", 32'(bus.recall_active), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
